// File: rtl/div_result_bcd_pkg.sv
// Shared types and constants for the divider result BCD conversion stage.
package div_result_bcd_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned ITER_COUNT = 8;
  localparam int unsigned BCD_W      = 4;
endpackage

// File: rtl/div_result_bcd_add3.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more.
module bcd_add3
  import div_result_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);
  assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;
endmodule

// File: rtl/div_result_bcd.sv
// Converts a divider quotient/remainder pair to sign + BCD digits.
// The quotient magnitude uses a serial shift-add-3 loop, one bit per cycle.
module div_result_bcd
  import div_result_bcd_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  quotient,
  input  logic [3:0]  remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        neg,
  output logic [11:0] q_bcd,
  output logic [7:0]  r_bcd,
  output logic        busy
);
  state_t      state, state_nxt;
  logic [3:0]  count;
  logic [19:0] sr;
  logic [11:0] bcd_fix;
  logic [19:0] sr_shift;
  logic        neg_i;
  logic [7:0]  r_bcd_i;
  logic [7:0]  mag_in;
  logic [7:0]  r_bcd_in;
  logic        last_iter;
  logic        accept;

  for (genvar g = 0; g < 3; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr[8 + 4*g +: 4]),
      .dout (bcd_fix[4*g +: 4])
    );
  end

  // {bcd, mag} register: correct digits first, then shift the whole word left.
  assign sr_shift  = {bcd_fix[10:0], sr[7:0], 1'b0};
  assign last_iter = (count == 4'(ITER_COUNT - 1));
  assign accept    = (state == IDLE) && in_valid;

  // 8'h80 negates to itself, which read as unsigned is the wanted 128.
  assign mag_in   = (SIGNED && quotient[7]) ? (~quotient + 8'd1) : quotient;
  assign r_bcd_in = (remainder >= 4'd10) ? {4'd1, remainder - 4'd10} : {4'd0, remainder};

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CONV);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CONV;
      CONV:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      sr      <= '0;
      neg_i   <= 1'b0;
      r_bcd_i <= '0;
      neg     <= 1'b0;
      q_bcd   <= '0;
      r_bcd   <= '0;
    end else if (accept) begin
      count   <= '0;
      sr      <= {12'd0, mag_in};
      neg_i   <= SIGNED & quotient[7];
      r_bcd_i <= r_bcd_in;
    end else if (state == CONV) begin
      count <= count + 4'd1;
      sr    <= sr_shift;
      if (last_iter) begin
        neg   <= neg_i;
        q_bcd <= sr_shift[19:8];
        r_bcd <= r_bcd_i;
      end
    end
  end
endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd: instance 0 is SIGNED=1, instance 1 is SIGNED=0.
module tb_div_result_bcd;
  typedef struct {
    logic        neg;
    logic [11:0] q;
    logic [7:0]  r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  quotient [2];
  logic [3:0]  remainder[2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic        neg      [2];
  logic [11:0] q_bcd    [2];
  logic [7:0]  r_bcd    [2];
  logic        busy     [2];

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sq0[$];
  exp_t sq1[$];

  always #5 clk = ~clk;

  div_result_bcd #(.SIGNED(1'b1)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .quotient(quotient[0]), .remainder(remainder[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .neg(neg[0]), .q_bcd(q_bcd[0]), .r_bcd(r_bcd[0]),
    .busy(busy[0])
  );

  div_result_bcd #(.SIGNED(1'b0)) u_u (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .quotient(quotient[1]), .remainder(remainder[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .neg(neg[1]), .q_bcd(q_bcd[1]), .r_bcd(r_bcd[1]),
    .busy(busy[1])
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic n, input logic [11:0] q, input logic [7:0] r);
    exp_t e;
    e.neg = n; e.q = q; e.r = r;
    if (k == 0) sq0.push_back(e);
    else        sq1.push_back(e);
  endtask

  // Results are popped on the handshake cycle only, so stalls never double-count.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!rst && out_valid[k] && out_ready[k]) begin
        if ((k == 0 && sq0.size() == 0) || (k == 1 && sq1.size() == 0)) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result inst%0d: got q_bcd %0h, expected no result", k, q_bcd[k]);
        end else begin
          e = (k == 0) ? sq0.pop_front() : sq1.pop_front();
          check($sformatf("neg inst%0d", k),   int'(neg[k]),   int'(e.neg));
          check($sformatf("q_bcd inst%0d", k), int'(q_bcd[k]), int'(e.q));
          check($sformatf("r_bcd inst%0d", k), int'(r_bcd[k]), int'(e.r));
        end
      end
    end
  end

  task automatic send(input int k, input logic [7:0] q, input logic [3:0] r,
                      input logic en, input logic [11:0] eq, input logic [7:0] er);
    int n;
    push_exp(k, en, eq, er);
    @(negedge clk);
    quotient[k] = q; remainder[k] = r; in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    quotient[k] = ~q; remainder[k] = ~r;
    check("in_ready_drop", int'(in_ready[k]), 0);
    check("busy_conv", int'(busy[k]), 1);
    n = 0;
    while (!out_valid[k] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 8);
  endtask

  initial begin
    int n;
    bit seen_idle;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; quotient[k] = '0; remainder[k] = '0; out_ready[k] = 1'b1;
    end
    #12;
    check("rst_in_ready",  int'(in_ready[0]),  1);
    check("rst_out_valid", int'(out_valid[0]), 0);
    check("rst_busy",      int'(busy[0]),      0);
    check("rst_q_bcd",     int'(q_bcd[0]),     0);
    check("rst_r_bcd",     int'(r_bcd[0]),     0);
    check("rst_neg",       int'(neg[1]),       0);
    @(negedge clk);
    rst = 1'b0;

    send(0, 8'd5,  4'd1,  1'b0, 12'h005, 8'h01);
    send(0, 8'hF2, 4'd4,  1'b1, 12'h014, 8'h04);
    send(0, 8'h80, 4'd10, 1'b1, 12'h128, 8'h10);
    send(1, 8'hFF, 4'd15, 1'b0, 12'h255, 8'h15);
    send(1, 8'h00, 4'd0,  1'b0, 12'h000, 8'h00);
    send(1, 8'h80, 4'd9,  1'b0, 12'h128, 8'h09);
    send(1, 8'hF2, 4'd4,  1'b0, 12'h242, 8'h04);

    // Backpressure: hold the result while inputs churn.
    out_ready[0] = 1'b0;
    send(0, 8'd99, 4'd12, 1'b0, 12'h099, 8'h12);
    repeat (5) begin
      @(posedge clk);
      #1;
      quotient[0] = 8'($urandom);
      in_valid[0] = ~in_valid[0];
      check("bp_q_bcd",     int'(q_bcd[0]),     12'h099);
      check("bp_out_valid", int'(out_valid[0]), 1);
      check("bp_in_ready",  int'(in_ready[0]),  0);
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", int'(out_valid[0]), 0);
    check("bp_release_in_ready",  int'(in_ready[0]),  1);
    check("bp_hold_after_done",   int'(q_bcd[0]),     12'h099);

    // Back-to-back with in_valid held high.
    push_exp(0, 1'b0, 12'h005, 8'h00);
    push_exp(0, 1'b1, 12'h051, 8'h03);
    @(negedge clk);
    quotient[0] = 8'd5; remainder[0] = 4'd0; in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    quotient[0] = 8'hCD; remainder[0] = 4'd3;
    n = 0; seen_idle = 1'b0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (busy[0] && seen_idle) break;
      if (!busy[0]) seen_idle = 1'b1;
    end
    in_valid[0] = 1'b0;
    check("b2b_second_accept", n, 10);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_second_latency", n, 8);
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    quotient[0] = 8'd42; remainder[0] = 4'd7; in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(out_valid[0]), 0);
    check("mid_rst_in_ready",  int'(in_ready[0]),  1);
    check("mid_rst_q_bcd",     int'(q_bcd[0]),     0);
    check("mid_rst_busy",      int'(busy[0]),      0);
    @(negedge clk);
    rst = 1'b0;
    send(0, 8'd42, 4'd7, 1'b0, 12'h042, 8'h07);
    send(0, 8'hFF, 4'd2, 1'b1, 12'h001, 8'h02);

    repeat (4) @(posedge clk);
    check("sq0_drained", sq0.size(), 0);
    check("sq1_drained", sq1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
